// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, start + 8 data LSB first + optional parity + 1/2 stop bits.
module uart_tx #(
  parameter int freq      = 50_000_000,
  parameter int baud_rate = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int B  = freq / baud_rate;
  localparam int CW = $clog2(B);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          ready_q, busy_q;
  logic          last;
  assign last = cnt_q == CW'(B - 1);
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (tx_start) begin
        shift_d = tx_data;
        par_d   = (PARITY == 2) ? ~^tx_data : ^tx_data;
        state_d = START;
      end
      START: if (last) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          bit_d   = 3'd0;
        end
      end
      PAR: if (last) begin
        state_d = STOP;
        bit_d   = 3'd0;
      end
      STOP: if (last) begin
        // bit_q doubles as the stop-bit counter
        if (bit_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA)  ? shift_d[0] :
           (state_d == PAR)   ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ready_q <= state_d == IDLE;
      busy_q  <= state_d != IDLE;
    end
  end
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
endmodule
